// File: rtl/prog_feeder_pkg.sv
// rtl/prog_feeder_pkg.sv - shared types and constants for the program feeder
package prog_feeder_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 16;

   // Opcode field of the processor instruction word
   localparam int OP_HI = 8;
   localparam int OP_LO = 6;
   localparam logic [2:0] OP_MVI = 3'b001;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_IMM   = 3'd4,
      ST_HALT  = 3'd5
   } feeder_state_t;

endpackage

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program memory: synchronous write, asynchronous read, no reset
module prog_ram #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_feeder.sv
// rtl/prog_feeder.sv - sequences host-loaded program words into the processor DIN/Run/Done port
module prog_feeder
   import prog_feeder_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 15
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              Done,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   output logic [ADDR_W:0]   pc,
   output logic              busy,
   output logic              halted,
   output logic              error
);

   localparam int PC_W = ADDR_W + 1;
   localparam int WD_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

   feeder_state_t     r_state;
   logic [DATA_W-1:0] r_din;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_len;
   logic [WD_W-1:0]   r_wd;
   logic              r_error;

   logic              w_idle_like;
   logic              w_we;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [DATA_W-1:0] w_rd_data;
   logic [PC_W-1:0]   w_next_pc;
   logic              w_is_mvi;
   logic              w_wd_expired;

   assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_HALT);
   assign w_we        = load_en && w_idle_like;

   // In ISSUE the read port already looks at the word after the instruction (the mvi immediate), wrapping at the top
   assign w_rd_addr    = (r_state == ST_ISSUE) ? (r_pc[ADDR_W-1:0] + ADDR_W'(1)) : r_pc[ADDR_W-1:0];
   assign w_next_pc    = r_pc + ((r_state == ST_IMM) ? PC_W'(2) : PC_W'(1));
   assign w_is_mvi     = (r_din[OP_HI:OP_LO] == OP_MVI);
   assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));

   prog_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .i_clk  (Clock),
      .i_we   (w_we),
      .i_waddr(load_addr),
      .i_wdata(load_data),
      .i_raddr(w_rd_addr),
      .o_rdata(w_rd_data)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= ST_IDLE;
         r_din   <= '0;
         r_pc    <= '0;
         r_len   <= '0;
         r_wd    <= '0;
         r_error <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  if (prog_len != '0) begin
                     r_len   <= prog_len;
                     r_pc    <= '0;
                     r_error <= 1'b0;
                     r_state <= ST_FETCH;
                  end else begin
                     r_state <= ST_HALT;
                  end
               end
            end
            ST_FETCH: begin
               r_din   <= w_rd_data;
               r_state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               r_wd <= '0;
               if (w_is_mvi) begin
                  r_din   <= w_rd_data;
                  r_state <= ST_IMM;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT, ST_IMM: begin
               // Done is checked first so it wins against a coincident timeout
               if (Done) begin
                  r_pc    <= w_next_pc;
                  r_state <= (w_next_pc >= r_len) ? ST_HALT : ST_FETCH;
               end else if (w_wd_expired) begin
                  r_error <= 1'b1;
                  r_state <= ST_HALT;
               end else begin
                  r_wd <= r_wd + WD_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign DIN    = r_din;
   assign Run    = (r_state == ST_ISSUE);
   assign pc     = r_pc;
   assign busy   = (r_state == ST_FETCH) || (r_state == ST_ISSUE) ||
                   (r_state == ST_WAIT)  || (r_state == ST_IMM);
   assign halted = (r_state == ST_HALT);
   assign error  = r_error;

endmodule

// File: tb/tb_prog_feeder.sv
// tb/tb_prog_feeder.sv - directed self-checking bench for prog_feeder
module tb_prog_feeder;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        load_en;
   logic [4:0]  load_addr;
   logic [15:0] load_data;
   logic        start;
   logic [5:0]  prog_len;
   logic        Done;
   logic [15:0] DIN;
   logic        Run;
   logic [5:0]  pc;
   logic        busy;
   logic        halted;
   logic        error;

   int n_tests = 0;
   int n_fail  = 0;
   int run_cnt = 0;

   prog_feeder #(
      .ADDR_W (5),
      .DATA_W (16),
      .TIMEOUT(15)
   ) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .load_en  (load_en),
      .load_addr(load_addr),
      .load_data(load_data),
      .start    (start),
      .prog_len (prog_len),
      .Done     (Done),
      .DIN      (DIN),
      .Run      (Run),
      .pc       (pc),
      .busy     (busy),
      .halted   (halted),
      .error    (error)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (Run === 1'b1) run_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge Clock);
   endtask

   task automatic load(input logic [4:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      step();
      load_en = 1'b0;
   endtask

   // Leaves the bench at the negedge of the FETCH cycle
   task automatic do_start(input logic [5:0] len);
      start    = 1'b1;
      prog_len = len;
      step();
      start = 1'b0;
   endtask

   task automatic wait_run(input string tag, input int budget);
      int k = 0;
      while (Run !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      chk(tag, 32'(Run), 32'd1);
   endtask

   initial begin
      int base;
      Resetn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; prog_len = '0; Done = 1'b0;
      step(); step();
      chk("rst_din", 32'(DIN), 32'h0);
      chk("rst_run", 32'(Run), 32'h0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_error", 32'(error), 32'h0);
      Resetn = 1'b1;
      step();

      // mv, mvi + immediate, Done two cycles after each Run
      load(5'd0, 16'h0008); load(5'd1, 16'h0048); load(5'd2, 16'h1234);
      base = run_cnt;
      do_start(6'd3);
      chk("t1_fetch_busy", 32'(busy), 32'd1);
      chk("t1_fetch_run", 32'(Run), 32'd0);
      step();
      chk("t1_run0", 32'(Run), 32'd1);
      chk("t1_din0", 32'(DIN), 32'h0008);
      step();
      chk("t1_wait_run", 32'(Run), 32'd0);
      step(); Done = 1'b1;
      step(); Done = 1'b0;
      chk("t1_pc1", 32'(pc), 32'd1);
      step();
      chk("t1_run1", 32'(Run), 32'd1);
      chk("t1_din1", 32'(DIN), 32'h0048);
      step();
      chk("t1_imm", 32'(DIN), 32'h1234);
      chk("t1_imm_run", 32'(Run), 32'd0);
      step(); Done = 1'b1;
      step(); Done = 1'b0;
      chk("t1_halted", 32'(halted), 32'd1);
      chk("t1_pc3", 32'(pc), 32'd3);
      chk("t1_error", 32'(error), 32'd0);
      step();
      chk("t1_run_pulses", 32'(run_cnt - base), 32'd2);

      // Done during FETCH and during ISSUE is ignored
      load(5'd0, 16'h0008); load(5'd1, 16'h0010);
      do_start(6'd2);
      Done = 1'b1;
      step();
      chk("t2_run", 32'(Run), 32'd1);
      step(); Done = 1'b0;
      chk("t2_wait_busy", 32'(busy), 32'd1);
      chk("t2_wait_pc", 32'(pc), 32'd0);
      chk("t2_wait_halted", 32'(halted), 32'd0);
      step();
      chk("t2_still_wait_pc", 32'(pc), 32'd0);
      chk("t2_still_wait_busy", 32'(busy), 32'd1);
      Done = 1'b1;
      step(); Done = 1'b0;
      chk("t2_pc1", 32'(pc), 32'd1);
      step();
      chk("t2_run2", 32'(Run), 32'd1);
      chk("t2_din2", 32'(DIN), 32'h0010);
      step(); Done = 1'b1;
      step(); Done = 1'b0;
      chk("t2_halted", 32'(halted), 32'd1);
      chk("t2_pc2", 32'(pc), 32'd2);

      // Watchdog: halt 15 cycles after entering WAIT
      do_start(6'd1);
      step(); step();
      repeat (14) step();
      chk("t3_pre_to_halted", 32'(halted), 32'd0);
      chk("t3_pre_to_busy", 32'(busy), 32'd1);
      step();
      chk("t3_to_halted", 32'(halted), 32'd1);
      chk("t3_to_error", 32'(error), 32'd1);
      chk("t3_to_pc", 32'(pc), 32'd0);
      do_start(6'd1);
      chk("t3_err_clear", 32'(error), 32'd0);
      step(); step();
      repeat (14) step();
      Done = 1'b1;
      step(); Done = 1'b0;
      chk("t3_done_wins_halted", 32'(halted), 32'd1);
      chk("t3_done_wins_error", 32'(error), 32'd0);
      chk("t3_done_wins_pc", 32'(pc), 32'd1);

      // mvi as the last of 32 words: immediate wraps to address 0
      for (int i = 1; i < 31; i++) load(5'(i), 16'h0008);
      load(5'd31, 16'h0048);
      load(5'd0, 16'h5A00);
      do_start(6'd32);
      for (int i = 0; i < 31; i++) begin
         wait_run("t4_run", 8);
         chk("t4_din", 32'(DIN), (i == 0) ? 32'h5A00 : 32'h0008);
         chk("t4_pc", 32'(pc), 32'(i));
         step(); Done = 1'b1;
         step(); Done = 1'b0;
      end
      wait_run("t4_run_last", 8);
      chk("t4_din_mvi", 32'(DIN), 32'h0048);
      chk("t4_pc_mvi", 32'(pc), 32'd31);
      step();
      chk("t4_imm_wrap", 32'(DIN), 32'h5A00);
      Done = 1'b1;
      step(); Done = 1'b0;
      chk("t4_halted", 32'(halted), 32'd1);
      chk("t4_pc33", 32'(pc), 32'd33);

      // Writes while busy are dropped; writes in HALT land
      do_start(6'd1);
      load_en = 1'b1; load_addr = 5'd0; load_data = 16'hFFFF;
      step();
      chk("t5_busy_din", 32'(DIN), 32'h5A00);
      step();
      load_en = 1'b0; Done = 1'b1;
      step(); Done = 1'b0;
      chk("t5_halted", 32'(halted), 32'd1);
      do_start(6'd1);
      step();
      chk("t5_mem_unchanged", 32'(DIN), 32'h5A00);
      step(); Done = 1'b1;
      step(); Done = 1'b0;
      load(5'd0, 16'hFFFF);
      do_start(6'd1);
      step();
      chk("t5_halt_write", 32'(DIN), 32'hFFFF);
      step(); Done = 1'b1;
      step(); Done = 1'b0;
      chk("t5_halted2", 32'(halted), 32'd1);

      // Reset during IMM, then rerun from preserved memory
      load(5'd0, 16'h0048); load(5'd1, 16'h1234);
      do_start(6'd2);
      step();
      chk("t6_din0", 32'(DIN), 32'h0048);
      step();
      chk("t6_imm", 32'(DIN), 32'h1234);
      Resetn = 1'b0;
      #1;
      chk("t6_rst_din", 32'(DIN), 32'h0);
      chk("t6_rst_run", 32'(Run), 32'h0);
      chk("t6_rst_pc", 32'(pc), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_halted", 32'(halted), 32'h0);
      chk("t6_rst_error", 32'(error), 32'h0);
      step(); Resetn = 1'b1;
      step();
      chk("t6_idle_busy", 32'(busy), 32'd0);
      do_start(6'd2);
      step();
      chk("t6_rerun_din0", 32'(DIN), 32'h0048);
      chk("t6_rerun_run", 32'(Run), 32'd1);
      step();
      chk("t6_rerun_imm", 32'(DIN), 32'h1234);
      Done = 1'b1;
      step(); Done = 1'b0;
      chk("t6_halted", 32'(halted), 32'd1);
      chk("t6_pc2", 32'(pc), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
